// File: rtl/erx_protocol_pkg.sv
// Shared elink receive definitions: packet field offsets, FSM states,
// burst stride and the routing helper used by the protocol block.
package erx_protocol_pkg;

   // Receive FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_BURST = 2'd2,
      ST_DRAIN = 2'd3
   } erx_state_t;

   // Output channel selector
   typedef enum logic [1:0] {
      CH_WR = 2'd0,
      CH_RD = 2'd1,
      CH_RR = 2'd2
   } erx_chan_t;

   // emesh packet field offsets
   localparam int WRITE_BIT = 0;
   localparam int DMODE_LSB = 1;
   localparam int CTRL_LSB  = 3;
   localparam int DST_LSB   = 8;
   localparam int DATA_LSB  = 40;
   localparam int SRC_LSB   = 72;

   // Address increment between consecutive burst writes
   localparam logic [31:0] BURST_STRIDE = 32'd8;

   // Frame patterns
   localparam logic [7:0] FRAME_ALL  = 8'hFF;
   localparam logic [7:0] FRAME_NONE = 8'h00;

   // Reads go to the read-request channel; writes addressed to this chip
   // are read responses; all other writes go to the write channel.
   function automatic erx_chan_t erx_route(input logic       write,
                                           input logic [11:0] dst_hi,
                                           input logic [11:0] chip_id);
      if (!write)
         return CH_RD;
      else if (dst_hi == chip_id)
         return CH_RR;
      else
         return CH_WR;
   endfunction

endpackage

// File: rtl/erx_chan_reg.sv
// Single-entry output register for one emesh channel. A pushed packet is
// loaded when the slot is empty or being accepted this cycle; otherwise it
// is dropped and reported through drop.
module erx_chan_reg #(
   parameter int PW = 104
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          push,
   input  logic [PW-1:0] push_packet,
   input  logic          stall,
   output logic          access,
   output logic [PW-1:0] packet,
   output logic          drop
);

   logic load;

   assign load = push & (~access | ~stall);
   assign drop = push & access & stall;

   // Valid flag: set on load, cleared once accepted, held while stalled
   // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)
         access <= 1'b0;
      else if (load)
         access <= 1'b1;
      else if (!stall)
         access <= 1'b0;
   end

   // Packet payload, only meaningful while access is high
   // NOTE: datapath registers are left unreset; access qualifies them, and no reset keeps the flops cheap.
   always_ff @(posedge clk) begin
      if (load)
         packet <= push_packet;
   end

endmodule

// File: rtl/erx_protocol.sv
// elink receive protocol: decodes 8-lane deserialized frames into emesh
// packets, routes them to write / read / read-response channels, and keeps
// sticky error, overflow and drop-count status.
module erx_protocol
   import erx_protocol_pkg::*;
#(
   parameter int          PW = 104,
   parameter logic [11:0] ID = 12'h000
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic [7:0]    rx_frame_par,
   input  logic [63:0]   rx_data_par,
   output logic          rxwr_access,
   output logic [PW-1:0] rxwr_packet,
   input  logic          rxwr_wait,
   output logic          rxrd_access,
   output logic [PW-1:0] rxrd_packet,
   input  logic          rxrd_wait,
   output logic          rxrr_access,
   output logic [PW-1:0] rxrr_packet,
   input  logic          rxrr_wait,
   output logic          rx_wr_wait,
   output logic          rx_rd_wait,
   input  logic          clear_status,
   output logic          rx_err,
   output logic          rx_ovf,
   output logic [7:0]    rx_drop_count
);

   erx_state_t    state, state_nxt;
   logic          prev_frame0;
   logic          frame_all, frame_none, start;
   logic [3:0]    hdr_ctrl;
   logic [1:0]    hdr_dmode;
   logic          hdr_write;
   logic [31:0]   hdr_dst;
   logic          hdr_capture, dst_advance, emit, err_set;
   logic [31:0]   emit_dst;
   logic [PW-1:0] emit_pkt;
   erx_chan_t     route;
   logic          push_wr, push_rd, push_rr;
   logic          drop_wr, drop_rd, drop_rr, drop_any;

   assign frame_all  = (rx_frame_par == FRAME_ALL);
   assign frame_none = (rx_frame_par == FRAME_NONE);
   assign start      = frame_all & ~prev_frame0;

   // State and previous-frame registers
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state       <= ST_IDLE;
         prev_frame0 <= 1'b0;
      end else begin
         state       <= state_nxt;
         prev_frame0 <= rx_frame_par[0];
      end
   end

   // Next-state, header capture, packet emit and framing-error decode
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value unassigned (no latch).
      state_nxt   = state;
      hdr_capture = 1'b0;
      dst_advance = 1'b0;
      emit        = 1'b0;
      err_set     = 1'b0;
      emit_dst    = hdr_dst;
      case (state)
         ST_IDLE: begin
            if (start) begin
               hdr_capture = 1'b1;
               state_nxt   = ST_DATA;
            end else if (!frame_none) begin
               err_set = 1'b1;
            end
         end
         ST_DATA: begin
            if (frame_all) begin
               emit      = 1'b1;
               state_nxt = hdr_write ? ST_BURST : ST_DRAIN;
            end else begin
               err_set   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (frame_all) begin
               emit        = 1'b1;
               dst_advance = 1'b1;
               emit_dst    = hdr_dst + BURST_STRIDE;
            end else begin
               err_set   = ~frame_none;
               state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (frame_none)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Header fields from the start cycle; dstaddr advances on each burst beat
   always_ff @(posedge clk) begin
      if (hdr_capture) begin
         hdr_ctrl  <= rx_data_par[63:60];
         hdr_dmode <= rx_data_par[59:58];
         hdr_write <= rx_data_par[57];
         hdr_dst   <= rx_data_par[55:24];
      end else if (dst_advance) begin
         hdr_dst <= emit_dst;
      end
   end

   // Assemble the emesh packet from header fields and the current data cycle
   always_comb begin
      emit_pkt                   = '0;
      emit_pkt[WRITE_BIT]        = hdr_write;
      emit_pkt[DMODE_LSB +: 2]   = hdr_dmode;
      emit_pkt[CTRL_LSB +: 5]    = {1'b0, hdr_ctrl};
      emit_pkt[DST_LSB +: 32]    = emit_dst;
      emit_pkt[DATA_LSB +: 32]   = rx_data_par[63:32];
      emit_pkt[SRC_LSB +: 32]    = rx_data_par[31:0];
   end

   assign route   = erx_route(hdr_write, emit_dst[31:20], ID);
   assign push_wr = emit & (route == CH_WR);
   assign push_rd = emit & (route == CH_RD);
   assign push_rr = emit & (route == CH_RR);

   erx_chan_reg #(.PW(PW)) u_wr (
      .clk(clk), .nreset(nreset), .push(push_wr), .push_packet(emit_pkt),
      .stall(rxwr_wait), .access(rxwr_access), .packet(rxwr_packet), .drop(drop_wr)
   );

   erx_chan_reg #(.PW(PW)) u_rd (
      .clk(clk), .nreset(nreset), .push(push_rd), .push_packet(emit_pkt),
      .stall(rxrd_wait), .access(rxrd_access), .packet(rxrd_packet), .drop(drop_rd)
   );

   erx_chan_reg #(.PW(PW)) u_rr (
      .clk(clk), .nreset(nreset), .push(push_rr), .push_packet(emit_pkt),
      .stall(rxrr_wait), .access(rxrr_access), .packet(rxrr_packet), .drop(drop_rr)
   );

   assign drop_any = drop_wr | drop_rd | drop_rr;

   // Registered pushback toward the io layer
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rx_wr_wait <= 1'b0;
         rx_rd_wait <= 1'b0;
      end else begin
         rx_wr_wait <= (rxwr_access & rxwr_wait) | (rxrr_access & rxrr_wait);
         rx_rd_wait <= rxrd_access & rxrd_wait;
      end
   end

   // Sticky status; clear_status wins over a same-cycle set or increment
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rx_err        <= 1'b0;
         rx_ovf        <= 1'b0;
         rx_drop_count <= 8'd0;
      end else if (clear_status) begin
         rx_err        <= 1'b0;
         rx_ovf        <= 1'b0;
         rx_drop_count <= 8'd0;
      end else begin
         rx_err <= rx_err | err_set;
         rx_ovf <= rx_ovf | drop_any;
         if (drop_any && (rx_drop_count != 8'hFF))
            rx_drop_count <= rx_drop_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_erx_protocol.sv
// Bench for erx_protocol: two instances (chip ID 12'h000 and 12'h808) share
// stimulus; a frame-level reference model predicts every output each cycle,
// and directed scenarios pin the model with literal expectations.
module tb_erx_protocol;

   localparam int          PW   = 104;
   localparam logic [11:0] ID_B = 12'h808;

   logic        clk    = 1'b0;
   logic        nreset = 1'b0;
   logic [7:0]  frame  = 8'h00;
   logic [63:0] data   = 64'h0;
   logic [2:0]  wt     = 3'b000;   // [0]=wr, [1]=rd, [2]=rr
   logic        clear  = 1'b0;

   logic [2:0]    acc0, acc1;
   logic [PW-1:0] pkt0 [3];
   logic [PW-1:0] pkt1 [3];
   logic [1:0]    wrw_o, rdw_o, err_o, ovf_o;
   logic [7:0]    cnt_o [2];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   erx_protocol #(.PW(PW), .ID(12'h000)) dut_a (
      .clk(clk), .nreset(nreset), .rx_frame_par(frame), .rx_data_par(data),
      .rxwr_access(acc0[0]), .rxwr_packet(pkt0[0]), .rxwr_wait(wt[0]),
      .rxrd_access(acc0[1]), .rxrd_packet(pkt0[1]), .rxrd_wait(wt[1]),
      .rxrr_access(acc0[2]), .rxrr_packet(pkt0[2]), .rxrr_wait(wt[2]),
      .rx_wr_wait(wrw_o[0]), .rx_rd_wait(rdw_o[0]), .clear_status(clear),
      .rx_err(err_o[0]), .rx_ovf(ovf_o[0]), .rx_drop_count(cnt_o[0])
   );

   erx_protocol #(.PW(PW), .ID(ID_B)) dut_b (
      .clk(clk), .nreset(nreset), .rx_frame_par(frame), .rx_data_par(data),
      .rxwr_access(acc1[0]), .rxwr_packet(pkt1[0]), .rxwr_wait(wt[0]),
      .rxrd_access(acc1[1]), .rxrd_packet(pkt1[1]), .rxrd_wait(wt[1]),
      .rxrr_access(acc1[2]), .rxrr_packet(pkt1[2]), .rxrr_wait(wt[2]),
      .rx_wr_wait(wrw_o[1]), .rx_rd_wait(rdw_o[1]), .clear_status(clear),
      .rx_err(err_o[1]), .rx_ovf(ovf_o[1]), .rx_drop_count(cnt_o[1])
   );

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit            prev0, awaiting, bursting, draining;
   logic [3:0]    m_ctrl;
   logic [1:0]    m_dm;
   logic          m_wr;
   logic [31:0]   m_dst;
   bit            exp_acc [2][3];
   logic [PW-1:0] exp_pkt [2][3];
   bit            exp_wrw [2];
   bit            exp_rdw [2];
   bit            exp_err [2];
   bit            exp_ovf [2];
   int            exp_cnt [2];

   task automatic model_reset();
      prev0 = 0; awaiting = 0; bursting = 0; draining = 0;
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 3; c++) exp_acc[d][c] = 0;
         exp_wrw[d] = 0; exp_rdw[d] = 0; exp_err[d] = 0; exp_ovf[d] = 0; exp_cnt[d] = 0;
      end
   endtask

   task automatic model_step();
      bit            emit = 0;
      bit            seterr = 0;
      logic [31:0]   pd = 32'h0;
      logic [PW-1:0] p;
      logic [11:0]   id;
      int            tgt;
      bit            drop;
      if (draining) begin
         if (frame == 8'h00) draining = 0;
      end else if (awaiting) begin
         awaiting = 0;
         if (frame == 8'hFF) begin
            emit = 1; pd = m_dst;
            if (m_wr) bursting = 1; else draining = 1;
         end else seterr = 1;
      end else if (bursting) begin
         if (frame == 8'hFF) begin
            emit = 1; m_dst = m_dst + 32'd8; pd = m_dst;
         end else begin
            bursting = 0; seterr = (frame != 8'h00);
         end
      end else begin
         if (frame == 8'hFF && !prev0) begin
            m_ctrl = data[63:60]; m_dm = data[59:58]; m_wr = data[57]; m_dst = data[55:24];
            awaiting = 1;
         end else seterr = (frame != 8'h00);
      end
      prev0 = frame[0];
      p = {data[31:0], data[63:32], pd, 1'b0, m_ctrl, m_dm, m_wr};
      for (int d = 0; d < 2; d++) begin
         id  = (d == 0) ? 12'h000 : ID_B;
         tgt = !m_wr ? 1 : ((pd[31:20] == id) ? 2 : 0);
         drop = 0;
         exp_wrw[d] = (exp_acc[d][0] & wt[0]) | (exp_acc[d][2] & wt[2]);
         exp_rdw[d] = exp_acc[d][1] & wt[1];
         for (int c = 0; c < 3; c++) begin
            if (emit && tgt == c && exp_acc[d][c] && wt[c]) drop = 1;
            else if (emit && tgt == c) begin exp_acc[d][c] = 1; exp_pkt[d][c] = p; end
            else if (!wt[c]) exp_acc[d][c] = 0;
         end
         if (clear) begin
            exp_err[d] = 0; exp_ovf[d] = 0; exp_cnt[d] = 0;
         end else begin
            exp_err[d] = exp_err[d] | seterr;
            exp_ovf[d] = exp_ovf[d] | drop;
            if (drop && exp_cnt[d] < 255) exp_cnt[d]++;
         end
      end
   endtask

   // Model advances on every clock edge; reset is asynchronous like the DUT
   always @(posedge clk or negedge nreset) begin
      if (!nreset) model_reset();
      else model_step();
   end

   // Compare all outputs against the model away from the active edge
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 3; c++) begin
            check($sformatf("acc d%0d c%0d", d, c), (d == 0) ? acc0[c] : acc1[c], exp_acc[d][c]);
            if (exp_acc[d][c])
               check($sformatf("pkt d%0d c%0d", d, c), (d == 0) ? pkt0[c] : pkt1[c], exp_pkt[d][c]);
         end
         check($sformatf("rx_wr_wait d%0d", d), wrw_o[d], exp_wrw[d]);
         check($sformatf("rx_rd_wait d%0d", d), rdw_o[d], exp_rdw[d]);
         check($sformatf("rx_err d%0d", d), err_o[d], exp_err[d]);
         check($sformatf("rx_ovf d%0d", d), ovf_o[d], exp_ovf[d]);
         check($sformatf("drop_count d%0d", d), cnt_o[d], exp_cnt[d]);
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [63:0] hdr(input logic [7:0] b7, input logic [31:0] dst);
      return {b7, dst, 24'h0};
   endfunction

   task automatic send(input logic [7:0] f, input logic [63:0] d);
      frame = f;
      data  = d;
      @(posedge clk);
      #2;
   endtask

   logic [7:0]  rf;
   logic [63:0] rd;
   int          r, sel;

   initial begin
      repeat (2) @(posedge clk);
      #2;
      nreset = 1'b1;
      check("reset acc a", acc0, 3'b000);
      check("reset acc b", acc1, 3'b000);
      check("reset status a", {err_o[0], ovf_o[0], wrw_o[0], rdw_o[0], cnt_o[0]}, 12'h0);

      // Single write routed to rxwr on instance a
      send(8'h00, 64'h0);
      send(8'hFF, hdr(8'h12, 32'h8080_0000));
      send(8'hFF, {32'hDEAD_BEEF, 32'h0000_0001});
      check("s1 wr access", acc0[0], 1'b1);
      check("s1 wr data", pkt0[0][71:40], 32'hDEAD_BEEF);
      check("s1 wr write bit", pkt0[0][0], 1'b1);
      check("s1 wr srcaddr", pkt0[0][103:72], 32'h0000_0001);
      send(8'h00, 64'h0);

      // Write to own chip ID lands on rxrr for instance b
      send(8'hFF, hdr(8'h12, 32'h8081_0000));
      send(8'hFF, {32'h1234_5678, 32'h0000_0002});
      check("s4 rr access b", acc1[2], 1'b1);
      check("s4 wr access b", acc1[0], 1'b0);
      check("s4 wr access a", acc0[0], 1'b1);
      send(8'h00, 64'h0);

      // Burst wrapping through 2^32 on instance b
      send(8'hFF, hdr(8'h12, 32'hFFFF_FFFC));
      send(8'hFF, {32'hA0A0_0001, 32'h0000_0010});
      check("s2 beat0 dst", {acc1[0], pkt1[0][39:8]}, {1'b1, 32'hFFFF_FFFC});
      send(8'hFF, {32'hA0A0_0002, 32'h0000_0011});
      check("s2 beat1 dst", {acc1[0], pkt1[0][39:8]}, {1'b1, 32'h0000_0004});
      send(8'hFF, {32'hA0A0_0003, 32'h0000_0012});
      check("s2 beat2 dst", {acc1[0], pkt1[0][39:8]}, {1'b1, 32'h0000_000C});
      send(8'h00, 64'h0);

      // Read: one packet, then drain until frame low
      send(8'hFF, hdr(8'h10, 32'h3000_0000));
      send(8'hFF, {32'h5555_AAAA, 32'h0000_0003});
      check("s3 rd access", acc0[1], 1'b1);
      check("s3 wr access", acc0[0], 1'b0);
      send(8'hFF, {32'h6666_0000, 32'h0});
      check("s3 drain no rd", acc0[1], 1'b0);
      send(8'hFF, {32'h7777_0000, 32'h0});
      check("s3 drain no rd2", acc0[1], 1'b0);
      send(8'h00, 64'h0);
      check("s3 no err", err_o[0], 1'b0);

      // Stalled write channel across 300 writes
      wt = 3'b001;
      send(8'hFF, hdr(8'h12, 32'h4000_0000));
      send(8'hFF, {32'hC0DE_0000, 32'h0});
      check("s5 wr_wait after load", wrw_o[0], 1'b0);
      send(8'hFF, {32'hC0DE_0001, 32'h0});
      check("s5 wr_wait next", wrw_o[0], 1'b1);
      for (int i = 0; i < 298; i++) send(8'hFF, {$urandom, $urandom});
      check("s5 ovf", ovf_o[0], 1'b1);
      check("s5 drop sat", cnt_o[0], 8'd255);
      check("s5 held packet", pkt0[0][71:40], 32'hC0DE_0000);
      send(8'h00, 64'h0);
      wt = 3'b000;
      send(8'h00, 64'h0);
      clear = 1'b1;
      send(8'h00, 64'h0);
      clear = 1'b0;
      check("s5 cleared", {err_o, ovf_o, cnt_o[0], cnt_o[1]}, 20'h0);

      // Framing error in DATA
      send(8'hFF, hdr(8'h12, 32'h5000_0000));
      send(8'h0F, 64'h0);
      check("s6 err", err_o, 2'b11);
      check("s6 no access", {acc0, acc1}, 6'b0);
      send(8'h00, 64'h0);

      // Reset in the middle of a burst
      send(8'hFF, hdr(8'h12, 32'h5000_0000));
      send(8'hFF, {32'h1, 32'h2});
      send(8'hFF, {32'h3, 32'h4});
      nreset = 1'b0;
      #1;
      check("s6 rst access", {acc0, acc1}, 6'b0);
      check("s6 rst status", {err_o, ovf_o, wrw_o, rdw_o, cnt_o[0], cnt_o[1]}, 24'h0);
      frame = 8'h00;
      @(posedge clk);
      #2;
      nreset = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         r  = $urandom_range(99);
         rf = (r < 35) ? 8'h00 : (r < 85) ? 8'hFF : 8'($urandom);
         rd = {$urandom, $urandom};
         sel = $urandom_range(2);
         if (sel == 0) rd[55:44] = 12'h000;
         else if (sel == 1) rd[55:44] = 12'h808;
         wt    = ($urandom_range(3) == 0) ? 3'($urandom) : 3'b000;
         clear = ($urandom_range(31) == 0);
         send(rf, rd);
      end
      clear = 1'b0;
      wt    = 3'b000;
      send(8'h00, 64'h0);
      send(8'h00, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/erx_protocol.md
ERX_PROTOCOL -- requirements
Module: erx_protocol

Interface
REQ-001 Parameters SHALL be: PW, default 104, emesh packet width; ID, default 12'h000, chip ID used for read-response routing.
REQ-002 The port list SHALL be as follows, clock and reset first:
- clk  in  1  core clock (rx_lclk_div4 domain).
- nreset  in  1  asynchronous active-low reset.
- rx_frame_par  in  8  deserialized frame, one bit per byte lane.
- rx_data_par  in  64  deserialized data; byte 7 = bits [63:56] is first on the wire.
- rxwr_access / rxwr_packet / rxwr_wait  out 1 / out PW / in 1  write channel.
- rxrd_access / rxrd_packet / rxrd_wait  out 1 / out PW / in 1  read-request channel.
- rxrr_access / rxrr_packet / rxrr_wait  out 1 / out PW / in 1  read-response channel.
- rx_wr_wait  out  1  write pushback to the io layer.
- rx_rd_wait  out  1  read pushback to the io layer.
- clear_status  in  1  synchronous clear of the status outputs.
- rx_err  out  1  sticky framing error.
- rx_ovf  out  1  sticky overflow.
- rx_drop_count  out  8  saturating count of dropped packets.

Function
REQ-003 Packet layout SHALL be: [0] write; [2:1] datamode; [7:3] ctrlmode, with bit 7 = 0; [39:8] dstaddr; [71:40] data; [103:72] srcaddr.
REQ-004 A start cycle SHALL be defined as rx_frame_par==8'hFF while the registered previous rx_frame_par[0]==0.
REQ-005 Header cycle layout SHALL be: byte7 = {ctrlmode[3:0], datamode[1:0], write, unused}; bytes 6..3 = dstaddr[31:0] MSB first; bytes 2..0 ignored.
REQ-006 Data cycle layout SHALL be: bytes 7..4 = data[31:0]; bytes 3..0 = srcaddr[31:0].
REQ-007 The FSM SHALL have exactly four states: IDLE, DATA, BURST and DRAIN.
- IDLE: on a start cycle, capture the header and go to DATA.
- IDLE: rx_frame_par not 8'h00 and not a start cycle sets rx_err.
- DATA: rx_frame_par==8'hFF assembles and emits a packet, then goes to BURST if write=1, else DRAIN.
- DATA: any other frame value sets rx_err and returns to IDLE with no packet.
- BURST: rx_frame_par==8'hFF emits a write with dstaddr = previous dstaddr + 8 (mod 2^32), carrying that cycle's data and srcaddr.
- BURST: rx_frame_par==8'h00 returns to IDLE; any other value sets rx_err and returns to IDLE.
- DRAIN: rx_frame_par==8'h00 returns to IDLE; all other cycles are ignored.
REQ-008 Routing SHALL be: write=0 goes to rxrd; write=1 with dstaddr[31:20]==ID goes to rxrr; write=1 otherwise goes to rxwr.
REQ-009 The packet SHALL appear on *_access/*_packet on the cycle after its DATA/BURST cycle (latency 1); each channel is a single output register.
REQ-010 Channel load rule: a packet SHALL be loaded when access==0 or wait==0 in the same cycle, and access is then 1 for the next cycle.
REQ-011 After acceptance (access & !wait) with no new load, access SHALL deassert on the next cycle; the packet SHALL hold stable while access & wait.
REQ-012 A routed packet arriving at a channel with access & wait SHALL be dropped, set rx_ovf, and increment rx_drop_count, saturating at 255.
REQ-013 rx_wr_wait SHALL be the registered value of (rxwr_access & rxwr_wait) | (rxrr_access & rxrr_wait); rx_rd_wait SHALL be the registered value of (rxrd_access & rxrd_wait).
REQ-014 clear_status SHALL zero rx_err, rx_ovf and rx_drop_count on the next edge, and SHALL win over a simultaneous set or increment.

Reset
REQ-015 On nreset low, asynchronously: FSM to IDLE, all *_access=0, rx_wr_wait=0, rx_rd_wait=0, rx_err=0, rx_ovf=0, rx_drop_count=0, previous-frame register=0; packet registers are don't-care.
REQ-016 Reset asserted mid-transaction SHALL discard the partial packet; after release, a new start cycle requires a preceding frame-low cycle.

Structure
REQ-017 Packet field offsets, FSM state encodings and the burst stride (8) SHALL live in the shared elink package.
REQ-018 One sub-module, erx_chan_reg (single-entry output register with drop detection), SHALL be instantiated three times.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Write, header byte7=8'h12, dstaddr=32'h8080_0000, then data=32'hDEAD_BEEF, srcaddr=32'h1 -> one cycle later rxwr_access=1, packet[71:40]=32'hDEAD_BEEF, packet[0]=1.
- Burst: write header at dstaddr=32'hFFFF_FFFC, three frame-high data cycles -> rxwr dstaddr 32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_000C on consecutive cycles.
- Read, write=0, frame high for 4 cycles -> exactly one rxrd packet, DRAIN until frame low, rx_err=0.
- ID=12'h808 with a write to 32'h8081_0000 -> rxrr_access=1, rxwr_access=0.
- rxwr_wait held high across 300 writes -> rx_wr_wait=1 two cycles after the first load, rx_ovf=1, rx_drop_count=255; clear_status -> all zero.
- Frame 8'hFF then 8'h0F in DATA -> rx_err=1, no access; nreset pulsed mid-burst -> all outputs 0 immediately.
